uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
//   Synchronises rx_i, detects the start-bit falling edge, rejects false
//   starts, then decides every bit by a 2-of-3 majority around mid-bit and
//   emits one word per frame with a one-cycle valid strobe.
// Ports:
//   clk_i, rst_i (async, active high)
//   rx_i          serial input, idle high
//   data_o        last received word (held until the next frame completes)
//   data_o_v      one-cycle strobe; data_o and the flags update this cycle
//   parity_err_o  parity mismatch on last frame (0 when PARITY=0)
//   frame_err_o   a stop bit was decided 0 on last frame
//   break_o       every bit after the start bit was decided 0
//   busy_o        receiver is not IDLE
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_o_v,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 busy_o
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] SMP0    = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SMP1    = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] DEC     = CW'(CLK_PER_BIT / 2 + 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_d;
  logic [CW-1:0]          cnt;
  logic [3:0]             bcnt;
  logic [1:0]             smp;
  logic [DATA_BITS-1:0]   shreg;
  logic                   ones, perr, ferr;
  logic                   fall, wrap, dec, maj, done;

  // Synchroniser flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_d   <= rx_s;
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign fall   = rx_d & ~rx_s;
  assign wrap   = (cnt == CNT_MAX);
  assign dec    = (cnt == DEC);
  // Third vote is the live sample taken in the decision cycle itself.
  assign maj    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_n = S_START;
      S_START: begin
        if (dec && maj) state_n = S_IDLE;        // false start
        else if (wrap)  state_n = S_DATA;
      end
      S_DATA:   if (wrap && bcnt == LAST_DATA)
                  state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) state_n = S_STOP;
      // Finish on the last stop decision so a back-to-back start is not missed.
      S_STOP: begin
        if (dec && bcnt == LAST_STOP) begin
          state_n = S_IDLE;
          done    = 1'b1;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt          <= '0;
      bcnt         <= '0;
      smp          <= '0;
      shreg        <= '0;
      ones         <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      data_o       <= '0;
      data_o_v     <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      data_o_v <= 1'b0;

      // Counter sits at 0 while idle and on the cycle of any return to idle.
      if (state == S_IDLE || state_n == S_IDLE) cnt <= '0;
      else if (wrap)                             cnt <= '0;
      else                                       cnt <= cnt + 1'b1;

      // Bit index restarts on every state change.
      if (state != state_n) bcnt <= '0;
      else if (wrap)        bcnt <= bcnt + 4'd1;

      if (cnt == SMP0) smp[0] <= rx_s;
      if (cnt == SMP1) smp[1] <= rx_s;

      if (state == S_IDLE && fall) begin
        ones <= 1'b0;
        perr <= 1'b0;
        ferr <= 1'b0;
      end

      if (dec) begin
        case (state)
          S_DATA: begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            ones  <= ones | maj;
          end
          S_PARITY: begin
            perr <= (^shreg) ^ maj ^ ODD;
            ones <= ones | maj;
          end
          S_STOP: begin
            ones <= ones | maj;
            if (!maj) ferr <= 1'b1;
          end
          default: ;
        endcase
      end

      if (done) begin
        data_o       <= shreg;
        data_o_v     <= 1'b1;
        parity_err_o <= perr;
        frame_err_o  <= ferr | ~maj;
        break_o      <= ~(ones | maj);
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;
  localparam int CPB [3] = '{16, 16, 8};
  localparam int DB  [3] = '{8, 8, 9};
  localparam int PAR [3] = '{0, 2, 0};
  localparam int SB  [3] = '{1, 2, 1};

  typedef struct {
    int         id;
    int         cyc;
    logic [8:0] data;
    logic       pe, fe, brk;
  } ev_t;

  logic clk = 1'b0, rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic [7:0] da, db;
  logic [8:0] dc;
  logic va, pa, fa, ba, ya;
  logic vb, pb, fb, bb, yb;
  logic vc, pc, fc, bc, yc;

  int   cyc = 0;
  int   ncmp = 0, nerr = 0;
  ev_t  gotq[$], expq[$];

  uart_rx_cfg u_a (.clk_i(clk), .rst_i(rst), .rx_i(rx_a), .data_o(da), .data_o_v(va),
    .parity_err_o(pa), .frame_err_o(fa), .break_o(ba), .busy_o(ya));
  uart_rx_cfg #(.PARITY(2), .STOP_BITS(2)) u_b (.clk_i(clk), .rst_i(rst), .rx_i(rx_b),
    .data_o(db), .data_o_v(vb), .parity_err_o(pb), .frame_err_o(fb), .break_o(bb), .busy_o(yb));
  uart_rx_cfg #(.CLK_PER_BIT(8), .DATA_BITS(9)) u_c (.clk_i(clk), .rst_i(rst), .rx_i(rx_c),
    .data_o(dc), .data_o_v(vc), .parity_err_o(pc), .frame_err_o(fc), .break_o(bc), .busy_o(yc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(int id, logic [8:0] d, logic pe, logic fe, logic brk);
    ev_t e;
    e.id = id; e.cyc = cyc; e.data = d; e.pe = pe; e.fe = fe; e.brk = brk;
    return e;
  endfunction

  always @(negedge clk) begin
    if (va) gotq.push_back(mk_ev(0, {1'b0, da}, pa, fa, ba));
    if (vb) gotq.push_back(mk_ev(1, {1'b0, db}, pb, fb, bb));
    if (vc) gotq.push_back(mk_ev(2, dc, pc, fc, bc));
  end

  function automatic int nbits(int id);
    return 1 + DB[id] + ((PAR[id] != 0) ? 1 : 0) + SB[id];
  endfunction

  // Start-edge-to-strobe latency with a 2-flop synchroniser.
  function automatic int lat(int id);
    return 2 + (nbits(id) - 1) * CPB[id] + CPB[id] / 2 + 2;
  endfunction

  // Line levels for one frame, bit 0 first on the wire.
  function automatic logic [31:0] build(int id, int data, bit pflip, int stop_zero);
    logic [31:0] b, dv, sz;
    logic x;
    int k;
    b = '1; dv = data; sz = stop_zero; x = 1'b0;
    b[0] = 1'b0;
    for (int i = 0; i < DB[id]; i++) begin
      b[1+i] = dv[i];
      x = x ^ dv[i];
    end
    k = 1 + DB[id];
    if (PAR[id] != 0) begin
      b[k] = ((PAR[id] == 1) ? ~x : x) ^ pflip;
      k++;
    end
    for (int s = 0; s < SB[id]; s++) b[k+s] = ~sz[s];
    return b;
  endfunction

  // What the receiver should report for a frame whose line levels are b.
  function automatic ev_t model(int id, logic [31:0] b);
    ev_t e;
    int k, ones, d;
    d = 0; ones = 0;
    for (int i = 0; i < DB[id]; i++) if (b[1+i]) begin d += (1 << i); ones++; end
    e.id = id; e.cyc = 0; e.data = 9'(d); e.pe = 1'b0; e.fe = 1'b0;
    k = 1 + DB[id];
    if (PAR[id] != 0) begin
      if (b[k]) ones++;
      // total ones (data + parity) must be odd for odd parity, even for even
      e.pe = (PAR[id] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      k++;
    end
    for (int s = 0; s < SB[id]; s++) if (!b[k+s]) e.fe = 1'b1; else ones++;
    e.brk = (ones == 0);
    return e;
  endfunction

  task automatic set_rx(int id, logic v);
    case (id)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive(int id, logic [31:0] b, int nb);
    for (int i = 0; i < nb; i++) begin
      set_rx(id, b[i]);
      repeat (CPB[id]) @(negedge clk);
    end
    set_rx(id, 1'b1);
  endtask

  task automatic send(int id, logic [31:0] b);
    ev_t e;
    e = model(id, b);
    e.cyc = cyc + 1 + lat(id);
    expq.push_back(e);
    drive(id, b, nbits(id));
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_events(int n, int budget);
    ev_t g, e;
    int w;
    w = 0;
    while (gotq.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < n; i++) begin
      e = expq.pop_front();
      if (gotq.size() == 0) begin
        chk($sformatf("i%0d_strobe_timeout", e.id), 0, 1);
      end else begin
        g = gotq.pop_front();
        chk($sformatf("i%0d_id", e.id),   g.id,   e.id);
        chk($sformatf("i%0d_lat", e.id),  g.cyc,  e.cyc);
        chk($sformatf("i%0d_data", e.id), g.data, e.data);
        chk($sformatf("i%0d_perr", e.id), g.pe,   e.pe);
        chk($sformatf("i%0d_ferr", e.id), g.fe,   e.fe);
        chk($sformatf("i%0d_brk", e.id),  g.brk,  e.brk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    logic seen;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_a_data", da, 0);
    chk("rst_a_flags", {va, pa, fa, ba, ya}, 0);
    chk("rst_b", {db, vb, pb, fb, bb, yb}, 0);
    chk("rst_c", {dc, vc, pc, fc, bc, yc}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // defaults: 0xA5 8N1, latency 156
    send(0, build(0, 'hA5, 0, 0));
    check_events(1, 2000);
    chk("a_hold_data", da, 'hA5);

    // even parity, two stop bits
    send(1, build(1, 'h37, 0, 0));
    check_events(1, 2000);
    send(1, build(1, 'h37, 1, 0));
    check_events(1, 2000);
    send(1, build(1, 'h96, 0, 2));          // second stop bit low
    repeat (CPB[1]) @(negedge clk);
    send(1, build(1, 'h5A, 0, 0));
    send(1, build(1, int'($urandom_range(0, 255)), 0, 0));  // back-to-back
    check_events(3, 2000);
    for (int i = 0; i < 4; i++) begin
      send(1, build(1, int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3))));
      repeat (CPB[1]) @(negedge clk);
      check_events(1, 2000);
    end

    // false start: 3-cycle low pulse
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    seen = 1'b0;
    repeat (2 * CPB[0]) begin
      @(negedge clk);
      seen = seen | ya;
    end
    chk("glitch_busy_seen", seen, 1);
    chk("glitch_busy_end", ya, 0);
    chk("glitch_no_strobe", gotq.size(), 0);
    send(0, build(0, 'h01, 0, 0));
    check_events(1, 2000);

    // break: line low for two frame times
    e = model(0, 32'h0);
    e.cyc = cyc + 1 + lat(0);
    expq.push_back(e);
    rx_a = 1'b0;
    repeat (2 * nbits(0) * CPB[0]) @(negedge clk);
    check_events(1, 100);
    chk("break_single_strobe", gotq.size(), 0);
    rx_a = 1'b1;
    repeat (CPB[0]) @(negedge clk);
    send(0, build(0, 'hC3, 0, 0));
    check_events(1, 2000);

    // reset mid-DATA on the default instance
    drive(0, build(0, 'hFF, 0, 0), 4);
    chk("a_busy_mid", ya, 1);
    #2 rst = 1'b1;
    #1;
    chk("a_async_rst_data", da, 0);
    chk("a_async_rst_flags", {va, pa, fa, ba, ya}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (nbits(0) * CPB[0]) @(negedge clk);
    chk("a_rst_no_strobe", gotq.size(), 0);
    send(0, build(0, 'h3C, 0, 0));
    check_events(1, 2000);

    // 9-bit, 8x oversample
    for (int i = 0; i < 3; i++) send(2, build(2, int'($urandom_range(1, 511)), 0, 0));
    check_events(3, 2000);
    drive(2, build(2, 'h1FF, 0, 0), 5);
    chk("c_busy_mid", yc, 1);
    #2 rst = 1'b1;
    #1;
    chk("c_async_rst", {dc, vc, pc, fc, bc, yc}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (nbits(2) * CPB[2]) @(negedge clk);
    chk("c_rst_no_strobe", gotq.size(), 0);
    send(2, build(2, 'h1C3, 0, 0));
    check_events(1, 2000);
    chk("c_hold_data", dc, 'h1C3);

    repeat (20) @(negedge clk);
    chk("no_stray_strobes", gotq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
